// File: rtl/zorro_int_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : zorro_int_ctrl
//  Brief    : Zorro-slave interrupt controller: PEND/MASK/VEC registers,
//             edge/level sources, combined INT_n, delayed int_dtack.
//  Revision : 1.0  initial release
// ============================================================================
module zorro_int_ctrl #(
    parameter int          NUM_SRC     = 4,
    parameter logic [27:0] BASE_ADDR   = 28'h900000,
    parameter logic [7:0]  EDGE_MASK   = 8'h01,
    parameter logic [7:0]  MASK_RST    = 8'hFF,
    parameter logic [7:0]  VECTOR_BASE = 8'h18,
    parameter bit          CLR_ON_READ = 1'b1,
    parameter int          DTACK_DLY   = 0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [27:0]        ADDR,
    input  logic               READ,
    input  logic               FCS_n,
    input  logic               slave_cycle,
    input  logic               configured,
    input  logic [7:0]         DIN,
    input  logic [NUM_SRC-1:0] SRC_INT,
    output logic               int_dtack,
    output logic               INT_n,
    output logic [7:0]         DOUT,
    output logic               DOE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [26:0]        c_PEND_ADDR = BASE_ADDR[27:1];
    localparam logic [26:0]        c_MASK_ADDR = BASE_ADDR[27:1] + 27'd1;
    localparam logic [26:0]        c_VEC_ADDR  = BASE_ADDR[27:1] + 27'd2;
    localparam logic [NUM_SRC-1:0] c_EDGE      = EDGE_MASK[NUM_SRC-1:0];
    localparam logic [NUM_SRC-1:0] c_MASK_RST  = MASK_RST[NUM_SRC-1:0];
    localparam logic [2:0]         c_DLY       = 3'(DTACK_DLY);

    logic [1:0]         r_state;
    logic [2:0]         r_cnt;
    logic               r_armed;
    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_pend_edge;
    logic [NUM_SRC-1:0] r_mask;
    logic               r_int_n;
    logic [7:0]         r_dout;

    logic [NUM_SRC-1:0] w_pend;
    logic [NUM_SRC-1:0] w_new_edge;
    logic [NUM_SRC-1:0] w_clr;
    logic               w_sel_pend;
    logic               w_sel_mask;
    logic               w_sel_vec;
    logic               w_start;
    logic [7:0]         w_pend8;
    logic [7:0]         w_mask8;
    logic [7:0]         w_vec;
    logic [7:0]         w_rdata;
    logic               w_unused_bits;

    assign w_unused_bits = ^{ADDR[0], DIN};

    // Level sources mirror the synchronised input; edge sources hold until cleared.
    assign w_pend     = (r_pend_edge & c_EDGE) | (r_src_q & ~c_EDGE);
    assign w_new_edge = SRC_INT & ~r_src_q & c_EDGE;

    assign w_sel_pend = (ADDR[27:1] == c_PEND_ADDR);
    assign w_sel_mask = (ADDR[27:1] == c_MASK_ADDR);
    assign w_sel_vec  = (ADDR[27:1] == c_VEC_ADDR);

    // r_armed blocks a restart until FCS_n has been seen high (e.g. after a reset mid-cycle).
    assign w_start = (r_state == S_IDLE) && r_armed && slave_cycle && configured && !FCS_n
                     && (w_sel_pend || w_sel_mask || w_sel_vec);

    always_comb begin
        w_pend8 = 8'h00;
        w_mask8 = 8'h00;
        w_pend8[NUM_SRC-1:0] = w_pend;
        w_mask8[NUM_SRC-1:0] = r_mask;
        w_vec = 8'hFF;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_pend[i] && r_mask[i]) begin
                w_vec = VECTOR_BASE + 8'(i);
            end
        end
        if (w_sel_pend) begin
            w_rdata = w_pend8;
        end else if (w_sel_mask) begin
            w_rdata = w_mask8;
        end else begin
            w_rdata = w_vec;
        end
    end

    always_comb begin
        w_clr = '0;
        if (w_start && w_sel_pend) begin
            if (!READ) begin
                w_clr = DIN[NUM_SRC-1:0] & c_EDGE;
            end else if (CLR_ON_READ) begin
                w_clr = w_pend & c_EDGE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_armed     <= 1'b0;
            r_src_q     <= '0;
            r_pend_edge <= '0;
            r_mask      <= c_MASK_RST;
            r_int_n     <= 1'b1;
            r_dout      <= 8'hFF;
        end else begin
            r_src_q <= SRC_INT;
            // A new edge overrides a clear landing on the same bit.
            r_pend_edge <= (r_pend_edge & ~w_clr) | w_new_edge;
            r_int_n     <= ~|(w_pend & r_mask);
            if (FCS_n) begin
                r_armed <= 1'b1;
            end
            if (w_start && !READ && w_sel_mask) begin
                r_mask <= DIN[NUM_SRC-1:0];
            end
            if (w_start) begin
                r_dout <= w_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_WAIT;
                        r_cnt   <= c_DLY;
                        r_armed <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (FCS_n) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 3'd0) begin
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_ACK: begin
                    if (FCS_n) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign int_dtack = (r_state == S_ACK);
    assign DOE       = READ && int_dtack;
    assign INT_n     = r_int_n;
    assign DOUT      = r_dout;

endmodule
`default_nettype wire
